// File: rtl/sys_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sys_ctrl_pkg
// Shared definitions for the sys_ctrl command-layer master:
//   - command byte codes recognised in IDLE
//   - FSM state encoding
//   - register-file addresses used for the two ALU operands
//   - small state-classification helpers
// -----------------------------------------------------------------------------
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_RD,
    ST_TX_LSB,
    ST_TX_MSB
  } state_e;

  // States that push a byte into the TX FIFO.
  function automatic logic is_tx_state(input state_e s);
    return (s == ST_TX_RD) || (s == ST_TX_LSB) || (s == ST_TX_MSB);
  endfunction

  // States that belong to an incoming frame (everything but IDLE and TX).
  function automatic logic is_frame_state(input state_e s);
    return (s != ST_IDLE) && !is_tx_state(s);
  endfunction

  // States in which an RX byte is consumed rather than dropped.
  function automatic logic takes_byte(input state_e s);
    return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
           (s == ST_ALU_A)   || (s == ST_ALU_B)   || (s == ST_ALU_FUN);
  endfunction

endpackage

// File: rtl/sys_ctrl_tx_push.sv
// -----------------------------------------------------------------------------
// sys_ctrl_tx_push
// Byte-push handshake towards the TX async FIFO. While req is high the byte on
// req_data is presented on tx_p_data (held in a register) and pushed with a
// single-cycle tx_d_vld in the first cycle FIFO_FULL is low. done is asserted
// combinationally in the cycle the push is committed so the owner can advance.
//
// Ports:
//   CLK, RST      clock, asynchronous active-low reset
//   req           a byte is waiting to be sent
//   req_data      byte to send
//   fifo_full     TX FIFO full, push is stalled while high
//   tx_p_data     registered byte to the FIFO
//   tx_d_vld      registered one-cycle FIFO write strobe
//   done          push accepted this cycle
// -----------------------------------------------------------------------------
module sys_ctrl_tx_push #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req,
  input  logic [WIDTH-1:0] req_data,
  input  logic             fifo_full,
  output logic [WIDTH-1:0] tx_p_data,
  output logic             tx_d_vld,
  output logic             done
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = 1'b0;
    done   = 1'b0;
    if (req) begin
      // The pending byte is presented while stalled so the data lines do not
      // move during a full condition.
      data_d = req_data;
      if (!fifo_full) begin
        vld_d = 1'b1;
        done  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign tx_p_data = data_q;
  assign tx_d_vld  = vld_q;

endmodule

// File: rtl/sys_ctrl.sv
// -----------------------------------------------------------------------------
// sys_ctrl
// Command-layer master between the UART RX byte stream, the register file, the
// ALU and the TX FIFO. Frames:
//   AA addr data      register write
//   BB addr           register read, read data returned as one TX byte
//   CC A B fun        write operands to regfile 0/1, run ALU, 2 TX bytes
//   DD fun            run ALU on current operands, 2 TX bytes (LSB first)
// Unknown command bytes in IDLE are ignored; bytes arriving while waiting for
// read data, ALU results or during TX are dropped.
//
// Build option: define SYS_CTRL_TIMEOUT_EN to abandon a frame that stalls for
// TIMEOUT_CYC cycles (TX states are exempt).
//
// Ports:
//   CLK, RST            clock, asynchronous active-low reset
//   RX_P_DATA/RX_D_VLD  received byte and its one-cycle strobe
//   WrEn/RdEn           regfile write/read strobes
//   Address/WrData      regfile address and write data
//   RdData/RdData_VLD   regfile read data and valid
//   ALU_EN/ALU_FUN      ALU start strobe and function code
//   ALU_OUT/ALU_OUT_VLD ALU result and valid
//   CLK_GATE_EN         ALU clock-gate enable
//   TX_P_DATA/TX_D_VLD  byte and write strobe to the TX FIFO
//   FIFO_FULL           TX FIFO full
// -----------------------------------------------------------------------------
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ADDR        = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   RX_P_DATA,
  input  logic               RX_D_VLD,
  output logic               WrEn,
  output logic               RdEn,
  output logic [ADDR-1:0]    Address,
  output logic [WIDTH-1:0]   WrData,
  input  logic [WIDTH-1:0]   RdData,
  input  logic               RdData_VLD,
  output logic               ALU_EN,
  output logic [3:0]         ALU_FUN,
  input  logic [2*WIDTH-1:0] ALU_OUT,
  input  logic               ALU_OUT_VLD,
  output logic               CLK_GATE_EN,
  output logic [WIDTH-1:0]   TX_P_DATA,
  output logic               TX_D_VLD,
  input  logic               FIFO_FULL
);

  // The frame counter needs at least one cycle of wait before forcing IDLE.
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout_cfg
    $error("sys_ctrl: TIMEOUT_CYC must be at least 2");
  end

  state_e             state_q, state_d;
  logic               wr_en_q, wr_en_d;
  logic               rd_en_q, rd_en_d;
  logic               alu_en_q, alu_en_d;
  logic               clk_gate_en_q, clk_gate_en_d;
  logic [ADDR-1:0]    address_q, address_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [3:0]         alu_fun_q, alu_fun_d;
  logic [ADDR-1:0]    addr_lat_q, addr_lat_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [2*WIDTH-1:0] alu_out_q, alu_out_d;

  logic               tx_req;
  logic [WIDTH-1:0]   tx_data;
  logic               tx_done;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`endif

  // Byte selection for the TX push unit.
  always_comb begin
    tx_req  = 1'b0;
    tx_data = rd_data_q;
    case (state_q)
      ST_TX_RD:  tx_req = 1'b1;
      ST_TX_LSB: begin
        tx_req  = 1'b1;
        tx_data = alu_out_q[WIDTH-1:0];
      end
      ST_TX_MSB: begin
        tx_req  = 1'b1;
        tx_data = alu_out_q[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    address_d  = address_q;
    wr_data_d  = wr_data_q;
    alu_fun_d  = alu_fun_q;
    addr_lat_d = addr_lat_q;
    rd_data_d  = rd_data_q;
    alu_out_d  = alu_out_q;

    case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR)           state_d = ST_WR_ADDR;
          else if (RX_P_DATA == CMD_RD)      state_d = ST_RD_ADDR;
          else if (RX_P_DATA == CMD_ALU_OP)  state_d = ST_ALU_A;
          else if (RX_P_DATA == CMD_ALU_NOP) state_d = ST_ALU_FUN;
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_lat_d = RX_P_DATA[ADDR-1:0];
          state_d    = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = addr_lat_q;
          wr_data_d = RX_P_DATA;
          state_d   = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          rd_en_d   = 1'b1;
          address_d = RX_P_DATA[ADDR-1:0];
          state_d   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (RdData_VLD) begin
          rd_data_d = RdData;
          state_d   = ST_TX_RD;
        end
      end
      ST_ALU_A: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDR'(OPA_ADDR);
          wr_data_d = RX_P_DATA;
          state_d   = ST_ALU_B;
        end
      end
      ST_ALU_B: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDR'(OPB_ADDR);
          wr_data_d = RX_P_DATA;
          state_d   = ST_ALU_FUN;
        end
      end
      ST_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_en_d  = 1'b1;
          alu_fun_d = RX_P_DATA[3:0];
          state_d   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          alu_out_d = ALU_OUT;
          state_d   = ST_TX_LSB;
        end
      end
      ST_TX_RD:  if (tx_done) state_d = ST_IDLE;
      ST_TX_LSB: if (tx_done) state_d = ST_TX_MSB;
      ST_TX_MSB: if (tx_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

`ifdef SYS_CTRL_TIMEOUT_EN
    // A stalled frame is abandoned: the strobe that the same cycle would have
    // produced is suppressed and the visible output registers keep their value.
    to_cnt_d = '0;
    if (is_frame_state(state_q)) begin
      if (to_cnt_q == TO_LAST) begin
        state_d   = ST_IDLE;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        address_d = address_q;
        wr_data_d = wr_data_q;
        alu_fun_d = alu_fun_q;
      end else if (!(RX_D_VLD && takes_byte(state_q))) begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif

    // Gate is on for every cycle spent in ALU_FUN or ALU_WAIT, which spans the
    // function-byte wait up to and including the result capture cycle.
    clk_gate_en_d = (state_d == ST_ALU_FUN) || (state_d == ST_ALU_WAIT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      alu_en_q      <= 1'b0;
      clk_gate_en_q <= 1'b0;
      address_q     <= '0;
      wr_data_q     <= '0;
      alu_fun_q     <= '0;
      addr_lat_q    <= '0;
      rd_data_q     <= '0;
      alu_out_q     <= '0;
`ifdef SYS_CTRL_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      alu_en_q      <= alu_en_d;
      clk_gate_en_q <= clk_gate_en_d;
      address_q     <= address_d;
      wr_data_q     <= wr_data_d;
      alu_fun_q     <= alu_fun_d;
      addr_lat_q    <= addr_lat_d;
      rd_data_q     <= rd_data_d;
      alu_out_q     <= alu_out_d;
`ifdef SYS_CTRL_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
`endif
    end
  end

  sys_ctrl_tx_push #(
    .WIDTH (WIDTH)
  ) u_tx_push (
    .CLK       (CLK),
    .RST       (RST),
    .req       (tx_req),
    .req_data  (tx_data),
    .fifo_full (FIFO_FULL),
    .tx_p_data (TX_P_DATA),
    .tx_d_vld  (TX_D_VLD),
    .done      (tx_done)
  );

  assign WrEn        = wr_en_q;
  assign RdEn        = rd_en_q;
  assign ALU_EN      = alu_en_q;
  assign CLK_GATE_EN = clk_gate_en_q;
  assign Address     = address_q;
  assign WrData      = wr_data_q;
  assign ALU_FUN     = alu_fun_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sys_ctrl
// Self-checking bench for sys_ctrl. A frame-level reference model turns each
// sent command frame into the expected regfile writes, reads, ALU starts and TX
// bytes; monitors collect what the DUT actually does and the two are compared.
// A small regfile and ALU responder model the peripherals.
// -----------------------------------------------------------------------------
module tb_sys_ctrl;

  localparam int TO_CYC = 1024;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic        WrEn, RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD;
  logic [3:0]  Address;
  logic [7:0]  WrData;
  logic [7:0]  RdData = 8'h00;
  logic        RdData_VLD = 1'b0;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        ALU_OUT_VLD = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        FIFO_FULL = 1'b0;

  sys_ctrl #(.WIDTH(8), .ADDR(4), .TIMEOUT_CYC(TO_CYC)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .RdData_VLD(RdData_VLD), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .CLK_GATE_EN(CLK_GATE_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ALU behaviour of the environment.
  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {a, b};
      default: return {f, 4'h0, a ^ b};
    endcase
  endfunction

  // Peripheral state and reference-model state.
  logic [7:0]  rf_mem [16];
  logic [7:0]  sh_mem [16];
  int          full_mode = 0;     // 0 never full, 1 always full, 2 random
  bit          alu_force = 1'b0;
  logic [15:0] alu_force_val = 16'h0;
  int          alu_cnt = 0;
  logic [3:0]  alu_fun_l = 4'h0;
  logic        full_at_edge = 1'b0;

  logic [11:0] exp_wr[$], obs_wr[$];
  logic [3:0]  exp_rd[$], obs_rd[$];
  logic [3:0]  exp_alu[$], obs_alu[$];
  logic [7:0]  exp_tx[$], obs_tx[$];
  int          mutex_viol = 0, full_viol = 0, gate_viol = 0;

  // Regfile: write on WrEn, read data valid one cycle after RdEn.
  always @(posedge CLK) begin
    if (WrEn) rf_mem[Address] <= WrData;
    RdData_VLD <= RdEn;
    if (RdEn) RdData <= rf_mem[Address];
  end

  // ALU: result 1..4 cycles after ALU_EN.
  always @(posedge CLK) begin
    ALU_OUT_VLD <= 1'b0;
    if (ALU_EN) begin
      alu_cnt   <= $urandom_range(1, 4);
      alu_fun_l <= ALU_FUN;
    end else if (alu_cnt > 0) begin
      alu_cnt <= alu_cnt - 1;
      if (alu_cnt == 1) begin
        ALU_OUT_VLD <= 1'b1;
        ALU_OUT     <= alu_force ? alu_force_val : alu_ref(rf_mem[0], rf_mem[1], alu_fun_l);
      end
    end
  end

  always @(posedge CLK) begin
    full_at_edge <= FIFO_FULL;
    #1;
    if (full_mode == 2) FIFO_FULL = ($urandom_range(0, 2) == 0);
    else                FIFO_FULL = (full_mode == 1);
  end

  // Monitor.
  always @(negedge CLK) begin
    if (RST) begin
      if (WrEn)     obs_wr.push_back({Address, WrData});
      if (RdEn)     obs_rd.push_back(Address);
      if (ALU_EN)   obs_alu.push_back(ALU_FUN);
      if (TX_D_VLD) obs_tx.push_back(TX_P_DATA);
      if ((int'(WrEn) + int'(RdEn) + int'(ALU_EN)) > 1) mutex_viol++;
      if (TX_D_VLD && full_at_edge) full_viol++;
      if ((ALU_EN || ALU_OUT_VLD) && !CLK_GATE_EN) gate_viol++;
      if (CLK_GATE_EN && TX_D_VLD) gate_viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (obs_tx.size() < exp_tx.size() && k < 400) begin
      @(negedge CLK);
      k++;
    end
    if (obs_tx.size() < exp_tx.size()) chk("drain_timeout", obs_tx.size(), exp_tx.size());
    @(posedge CLK); #1;
  endtask

  // Frame-level reference model plus stimulus.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input bit noise);
    logic [15:0] r;
    logic [7:0]  bs [4];
    int n;
    bs[0] = cmd; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    n = 1;
    if (cmd == 8'hAA) begin
      n = 3;
      exp_wr.push_back({b1[3:0], b2});
      sh_mem[b1[3:0]] = b2;
    end else if (cmd == 8'hBB) begin
      n = 2;
      exp_rd.push_back(b1[3:0]);
      exp_tx.push_back(sh_mem[b1[3:0]]);
    end else if (cmd == 8'hCC) begin
      n = 4;
      exp_wr.push_back({4'd0, b1});
      exp_wr.push_back({4'd1, b2});
      sh_mem[0] = b1;
      sh_mem[1] = b2;
      exp_alu.push_back(b3[3:0]);
      r = alu_ref(b1, b2, b3[3:0]);
      exp_tx.push_back(r[7:0]);
      exp_tx.push_back(r[15:8]);
    end else if (cmd == 8'hDD) begin
      n = 2;
      exp_alu.push_back(b1[3:0]);
      r = alu_ref(sh_mem[0], sh_mem[1], b1[3:0]);
      exp_tx.push_back(r[7:0]);
      exp_tx.push_back(r[15:8]);
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick($urandom_range(0, 2));
      send_byte(bs[i]);
    end
    // A command byte landing in a wait state must be dropped.
    if (noise && n >= 2 && cmd != 8'hAA) send_byte(8'hAA);
    drain();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_WrEn"},        WrEn,        0);
    chk({tag, "_RdEn"},        RdEn,        0);
    chk({tag, "_ALU_EN"},      ALU_EN,      0);
    chk({tag, "_Address"},     Address,     0);
    chk({tag, "_WrData"},      WrData,      0);
    chk({tag, "_ALU_FUN"},     ALU_FUN,     0);
    chk({tag, "_CLK_GATE_EN"}, CLK_GATE_EN, 0);
    chk({tag, "_TX_P_DATA"},   TX_P_DATA,   0);
    chk({tag, "_TX_D_VLD"},    TX_D_VLD,    0);
  endtask

  initial begin
    logic [7:0] held, c, j;
    int unstable, k, sel;
    RST = 1'b0; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 8'($urandom);
      sh_mem[i] = rf_mem[i];
    end
    repeat (2) @(posedge CLK); #1;
    check_outputs_zero("reset");
    RST = 1'b1;
    tick(2);

    // Directed frames.
    send_frame(8'hAA, 8'h05, 8'h3C, 8'h00, 1'b0);
    chk("wr_no_tx", obs_tx.size(), 0);
    send_frame(8'hBB, 8'h05, 8'h00, 8'h00, 1'b1);
    send_frame(8'hCC, 8'h0A, 8'h03, 8'h00, 1'b1);

    // ALU without operands against a full FIFO.
    full_mode = 1; alu_force = 1'b1; alu_force_val = 16'h1234;
    tick(2);
    chk("gate_idle", CLK_GATE_EN, 0);
    exp_alu.push_back(4'h2);
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12);
    send_byte(8'hDD);
    chk("gate_entry", CLK_GATE_EN, 1);
    send_byte(8'h02);
    k = 0;
    do begin @(negedge CLK); k++; end while (!ALU_OUT_VLD && k < 20);
    chk("alu_vld_seen", ALU_OUT_VLD, 1);
    repeat (2) @(negedge CLK);
    held = TX_P_DATA;
    unstable = 0;
    repeat (5) begin
      @(negedge CLK);
      if (TX_P_DATA !== held) unstable++;
    end
    chk("tx_held_while_full", unstable, 0);
    chk("no_push_while_full", obs_tx.size(), exp_tx.size() - 2);
    full_mode = 0;
    drain();
    alu_force = 1'b0;

    // Unknown command then a write.
    send_frame(8'h77, 8'h00, 8'h00, 8'h00, 1'b0);
    send_frame(8'hAA, 8'h01, 8'hFF, 8'h00, 1'b0);

    // Randomized frames with random FIFO back-pressure.
    full_mode = 2;
    for (int f = 0; f < 60; f++) begin
      sel = $urandom_range(0, 4);
      j = 8'($urandom);
      if (j == 8'hAA || j == 8'hBB || j == 8'hCC || j == 8'hDD) j = 8'h00;
      case (sel)
        0: c = 8'hAA;
        1: c = 8'hBB;
        2: c = 8'hCC;
        3: c = 8'hDD;
        default: c = j;
      endcase
      send_frame(c, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      tick($urandom_range(0, 3));
    end
    full_mode = 0;
    tick(4);

    // Reset in the middle of a write frame.
    send_byte(8'hAA);
    send_byte(8'h02);
    #2 RST = 1'b0;
    #1 check_outputs_zero("midrst");
    @(posedge CLK); #1;
    RST = 1'b1;
    tick(2);
    send_frame(8'hAA, 8'h02, 8'h11, 8'h00, 1'b0);

`ifdef SYS_CTRL_TIMEOUT_EN
    // Stalled write frame is abandoned; its late bytes are then ignored in IDLE.
    send_byte(8'hAA);
    tick(TO_CYC + 5);
    chk("timeout_gate", CLK_GATE_EN, 0);
    send_byte(8'h01);
    send_byte(8'hFF);
    tick(3);
    send_frame(8'hAA, 8'h03, 8'h44, 8'h00, 1'b0);
`endif

    tick(5);

    chk("wr_count", obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) chk($sformatf("wr[%0d]", i), obs_wr[i], exp_wr[i]);
    chk("rd_count", obs_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++) chk($sformatf("rd[%0d]", i), obs_rd[i], exp_rd[i]);
    chk("alu_count", obs_alu.size(), exp_alu.size());
    for (int i = 0; i < exp_alu.size() && i < obs_alu.size(); i++) chk($sformatf("alu[%0d]", i), obs_alu[i], exp_alu[i]);
    chk("tx_count", obs_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) chk($sformatf("tx[%0d]", i), obs_tx[i], exp_tx[i]);
    chk("strobe_mutex", mutex_viol, 0);
    chk("push_when_full", full_viol, 0);
    chk("clk_gate", gate_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
Command-layer master for the register file and ALU. It parses framed command bytes from the UART-RX data-sync path and issues register-file write/read strobes and ALU operations. It returns read data and ALU results as bytes into the TX async FIFO. It is the initiator end of the register-file WrEn/RdEn/Address/WrData/RdData/RdData_VLD interface.

Parameters:
WIDTH, 8, data byte / register width
ADDR, 4, register-file address width
TIMEOUT_CYC, 1024, frame-timeout cycle count (used only with SYS_CTRL_TIMEOUT_EN)

Ports:
CLK  in  1  reference clock
RST  in  1  asynchronous reset, active-low
RX_P_DATA  in  WIDTH  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
WrEn  out  1  regfile write strobe
RdEn  out  1  regfile read strobe
Address  out  ADDR  regfile address
WrData  out  WIDTH  regfile write data
RdData  in  WIDTH  regfile read data
RdData_VLD  in  1  regfile read data valid
ALU_EN  out  1  ALU operation strobe
ALU_FUN  out  4  ALU function code
ALU_OUT  in  2*WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid
CLK_GATE_EN  out  1  ALU clock-gate enable
TX_P_DATA  out  WIDTH  byte to TX FIFO
TX_D_VLD  out  1  TX FIFO write strobe
FIFO_FULL  in  1  TX FIFO full

Behaviour:
- Reset is asynchronous and active-low on RST; the block is clocked on posedge CLK. On reset: FSM=IDLE, all outputs 0, and internal address/result latches are 0.
- All outputs are registered. A strobe asserts in the cycle after the edge that accepted the triggering byte and lasts exactly 1 cycle.
- Command codes: 0xAA = write (addr, data); 0xBB = read (addr); 0xCC = ALU with operands (A, B, fun); 0xDD = ALU without operands (fun).
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_RD, TX_LSB, TX_MSB.
- IDLE: on RX_D_VLD, decode the byte:
  - AA goes to WR_ADDR.
  - BB goes to RD_ADDR.
  - CC goes to ALU_A.
  - DD goes to ALU_FUN.
  - Any other code is ignored and the FSM stays in IDLE.
- WR_ADDR: latch RX_P_DATA[ADDR-1:0] as the address. Upper address bits are discarded.
- WR_DATA: on a byte, pulse WrEn with Address=latched address and WrData=byte, then return to IDLE.
- RD_ADDR: on a byte, pulse RdEn with Address=byte[ADDR-1:0], then go to RD_WAIT.
- RD_WAIT: on the first RdData_VLD=1, capture RdData and go to TX_RD.
- ALU_A: on a byte, pulse WrEn with Address=0 and WrData=byte. ALU_B does the same with Address=1. Then go to ALU_FUN.
- ALU_FUN: on a byte, latch ALU_FUN=byte[3:0] and pulse ALU_EN, then go to ALU_WAIT.
  - CLK_GATE_EN is 1 from the ALU_FUN entry cycle until the ALU_OUT_VLD capture cycle inclusive. It is 0 otherwise.
- ALU_WAIT: on ALU_OUT_VLD, capture ALU_OUT and go to TX_LSB.
- TX states: each byte is pushed with a 1-cycle TX_D_VLD, and only in a cycle where FIFO_FULL=0. While FIFO_FULL=1 the FSM holds and TX_P_DATA is held stable.
  - TX_RD sends the captured RdData, then goes to IDLE.
  - TX_LSB sends ALU_OUT[7:0], then TX_MSB sends ALU_OUT[15:8], then go to IDLE.
- RX_D_VLD in RD_WAIT, ALU_WAIT or any TX state: the byte is dropped with no side effects.
- WrEn and RdEn are never asserted in the same cycle. WrEn, RdEn and ALU_EN are mutually exclusive.
- Reset mid-frame: immediate return to IDLE, all strobes deassert, and the partial frame is discarded.

Optional Feature:
SYS_CTRL_TIMEOUT_EN
- Defined: a counter clears on every accepted byte and on IDLE. In WR_*, RD_*, ALU_* (including RD_WAIT and ALU_WAIT) it counts, and at TIMEOUT_CYC-1 the FSM forces IDLE. Any pending strobes are not issued, and CLK_GATE_EN drops the next cycle. TX states are exempt.
- Undefined: no counter; the FSM waits indefinitely for bytes and valids.

Decomposition:
- Package sys_ctrl_pkg: command constants (CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD), the state encoding, and the ALU operand addresses (OPA_ADDR=0, OPB_ADDR=1).
- One sub-module: sys_ctrl_tx_push. It is a byte-push handshake with a held data register, taking FIFO_FULL and a load request and producing TX_P_DATA/TX_D_VLD/done.

Test Plan:
- Send AA,05,3C → exactly one WrEn cycle with Address=5 and WrData=0x3C; no TX_D_VLD.
- Send BB,05 with regfile returning 0x3C one cycle after RdEn → single RdEn pulse with Address=5, then TX_P_DATA=0x3C with one TX_D_VLD.
- Send CC,0A,03,00; ALU returns 0x000D → WrEn at addr0=0x0A and addr1=0x03, ALU_EN with ALU_FUN=0, CLK_GATE_EN high through valid; TX bytes 0x0D then 0x00.
- Send DD,02 with ALU_OUT=0x1234 and FIFO_FULL=1 for 5 cycles → no TX_D_VLD while full, TX_P_DATA held; then bytes 0x34 then 0x12.
- Send 0x77 then AA,01,FF → 0x77 ignored; WrEn at addr1=0xFF.
- Send AA,02 and pull RST low → outputs 0; next AA,02,11 writes 0x11 to addr2. With SYS_CTRL_TIMEOUT_EN: AA then idle for TIMEOUT_CYC cycles → returns to IDLE with no WrEn.
